multicycle_control: RTL and testbench

Multi-cycle controller for the MIPS datapath: a Moore state machine that sequences instruction fetch, decode, execute, memory and write-back over several clocks, sharing one ALU and one unified instruction/data memory. Replaces single-cycle control when the datapath is rebuilt around an instruction register and a shared memory port. Supported opcodes: R-type, lw, sw, beq, addi, ori, j. A ready handshake on the memory port supports variable-latency memory.

---
 rtl/mc_ctrl_pkg.sv | 58 +++++
 rtl/mc_ctrl_outdec.sv | 75 +++++++
 rtl/multicycle_control.sv | 94 +++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ORIEX  = 4'd10,
        IMMWB  = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ADD   = 2'b00;
    localparam logic [1:0] SUB   = 2'b01;
    localparam logic [1:0] FUNCT = 2'b10;
    localparam logic [1:0] OR    = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decode: control word from state, with mem_ready
// qualifying the instruction-register and PC loads during fetch.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ADD;
                ctrl.pcsource = PCSRC_ALU;
                ctrl.irwrite  = mem_ready;
                ctrl.pcwrite  = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ADD;
            end
            MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = FUNCT;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_RT;
                ctrl.aluop       = SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            ORIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = OR;
            end
            IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state
// logic and reset gating of the decoded control outputs.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state;
    state_t next;
    ctrl_t  dec;
    ctrl_t  ctrl;
    logic   illegal;

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= next;
    end

    always_comb begin
        next    = FETCH;
        illegal = 1'b0;
        case (state)
            FETCH:  next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = EXEC;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEX;
                    OP_ORI:       next = ORIEX;
                    OP_J:         next = JUMP;
                    default: begin
                        next    = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: next = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next = mem_ready ? MEMWB : MEMRD;
            MEMWR:  next = mem_ready ? FETCH : MEMWR;
            EXEC:   next = ALUWB;
            ADDIEX: next = IMMWB;
            ORIEX:  next = IMMWB;
            default: next = FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (dec)
    );

    // Reset cycles must not leak strobes, even mid-instruction.
    assign ctrl      = rst ? '0 : dec;
    assign State     = rst ? 4'd0 : state;
    assign IllegalOp = ~rst & illegal;

    assign PCWrite     = ctrl.pcwrite;
    assign PCWriteCond = ctrl.pcwritecond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.memread;
    assign MemWrite    = ctrl.memwrite;
    assign IRWrite     = ctrl.irwrite;
    assign MemtoReg    = ctrl.memtoreg;
    assign RegDst      = ctrl.regdst;
    assign RegWrite    = ctrl.regwrite;
    assign ALUSrcA     = ctrl.alusrca;
    assign ALUSrcB     = ctrl.alusrcb;
    assign ALUOp       = ctrl.aluop;
    assign PCSource    = ctrl.pcsource;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model
// expands each instruction into expected per-cycle control words.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rd;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] pcs;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    multicycle_control dut (
        .clk         (clk),
        .rst         (rst),
        .Op          (Op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .IllegalOp   (IllegalOp),
        .State       (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    // Phase numbers follow the documented state encodings.
    function automatic exp_t exp_of(int ph, logic rdy, logic ill);
        exp_t e;
        e = '0;
        e.st = ph[3:0];
        case (ph)
            0:  begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            1:  begin e.asb = 2'b11; e.ill = ill; end
            2:  begin e.asa = 1; e.asb = 2'b10; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.m2r = 1; e.rw = 1; end
            5:  begin e.mw = 1; e.iord = 1; end
            6:  begin e.asa = 1; e.aop = 2'b10; end
            7:  begin e.rd = 1; e.rw = 1; end
            8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
            9:  begin e.asa = 1; e.asb = 2'b10; end
            10: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; end
            11: begin e.rw = 1; end
            12: begin e.pcw = 1; e.pcs = 2'b10; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                          6'b001000, 6'b001101, 6'b000010};
    endfunction

    task automatic tick(logic r, logic [5:0] op, logic rdy, exp_t e);
        rst       = r;
        Op        = op;
        mem_ready = rdy;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycles(int n);
        for (int i = 0; i < n; i++)
            tick(1'b1, 6'($urandom), 1'($urandom), '0);
    endtask

    task automatic plain(int ph, logic [5:0] op);
        logic r;
        r = 1'($urandom);
        tick(1'b0, op, r, exp_of(ph, r, 1'b0));
    endtask

    task automatic memwait(int ph, int w);
        for (int i = 0; i <= w; i++)
            tick(1'b0, 6'($urandom), (i == w), exp_of(ph, 1'b0, 1'b0));
    endtask

    task automatic fetch_decode(logic [5:0] op, int fw);
        logic r;
        for (int i = 0; i <= fw; i++)
            tick(1'b0, 6'($urandom), (i == fw), exp_of(0, (i == fw), 1'b0));
        r = 1'($urandom);
        tick(1'b0, op, r, exp_of(1, r, !legal(op)));
    endtask

    task automatic run_instr(logic [5:0] op, int fw, int mw);
        fetch_decode(op, fw);
        case (op)
            6'b100011: begin plain(2, op); memwait(3, mw); plain(4, 6'($urandom)); end
            6'b101011: begin plain(2, op); memwait(5, mw); end
            6'b000000: begin plain(6, 6'($urandom)); plain(7, 6'($urandom)); end
            6'b000100: plain(8, 6'($urandom));
            6'b001000: begin plain(9, 6'($urandom)); plain(11, 6'($urandom)); end
            6'b001101: begin plain(10, 6'($urandom)); plain(11, 6'($urandom)); end
            6'b000010: plain(12, 6'($urandom));
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        cyc++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {State, IllegalOp, PCWrite, PCWriteCond, IorD, MemRead,
                 MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSource};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl cycle %0d: got state=%0d word=%h, required state=%0d word=%h",
                         cyc, a.st, a, e.st, e);
            end
        end
    end

    logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b001000, 6'b001101, 6'b000010};

    initial begin
        logic [5:0] op;
        rst = 1'b1;
        Op = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_cycles(3);
        run_instr(6'b100011, 2, 0);
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b001101, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b001000, 1, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b100011, 0, 2);
        fetch_decode(6'b101011, 0);
        plain(2, 6'b101011);
        tick(1'b0, 6'($urandom), 1'b0, exp_of(5, 1'b0, 1'b0));
        tick(1'b0, 6'($urandom), 1'b0, exp_of(5, 1'b0, 1'b0));
        rst_cycles(2);
        run_instr(6'b000000, 0, 0);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                op = 6'($urandom);
            else
                op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                rst_cycles($urandom_range(1, 2));
        end
        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
